// File: rtl/sram_arbiter_pkg.sv
// Shared SRAM definitions: geometry, client indices and the packed request record
// used by the external SRAM arbiter.
package sram_arbiter_pkg;

  localparam int SRAM_ADDR_COUNT    = 1048576;
  localparam int SRAM_ADDR_WIDTH    = $clog2(SRAM_ADDR_COUNT);
  localparam int SRAM_DATA_WIDTH    = 16;
  localparam int SRAM_BE_WIDTH      = SRAM_DATA_WIDTH / 8;
  localparam int SRAM_ACCESS_CYCLES = 2;

  localparam int CLIENT_VGA    = 0;
  localparam int CLIENT_SPRITE = 1;
  localparam int CLIENT_LOADER = 2;

  typedef struct packed {
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_DATA_WIDTH-1:0] wdata;
    logic                       we;
    logic [SRAM_BE_WIDTH-1:0]   be;
  } sram_req_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } sram_state_t;

endpackage

// File: rtl/sram_rr_select.sv
// Combinational grant select: VGA client wins outright, remaining clients are
// served round-robin starting at ptr (which always lies in 1..N-1).
module sram_rr_select
  import sram_arbiter_pkg::*;
#(
  parameter int N  = CLIENT_LOADER + 1,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr_next
);

  logic found;
  int   c;

  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    c        = 0;
    if (req[CLIENT_VGA]) begin
      grant[CLIENT_VGA] = 1'b1;
    end else begin
      for (int k = 0; k < N - 1; k++) begin
        // Walk the ring 1..N-1, wrapping back to 1 rather than to 0.
        c = int'(ptr) + k;
        if (c >= N) c = c - (N - 1);
        if (!found && req[c]) begin
          found    = 1'b1;
          grant[c] = 1'b1;
          ptr_next = (c == N - 1) ? PW'(CLIENT_SPRITE) : PW'(c + 1);
        end
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Owns the external 1M x 16 SRAM pins and runs one fixed-length access at a time
// for the VGA, sprite and loader clients.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS   = CLIENT_LOADER + 1,
  parameter int ACCESS_CYCLES = SRAM_ACCESS_CYCLES
) (
  input  logic                                           i_clk,
  input  logic                                           i_rst_n,
  input  logic [NUM_CLIENTS-1:0]                         i_req,
  input  logic [NUM_CLIENTS-1:0]                         i_we,
  input  logic [NUM_CLIENTS-1:0][SRAM_ADDR_WIDTH-1:0]    i_addr,
  input  logic [NUM_CLIENTS-1:0][SRAM_DATA_WIDTH-1:0]    i_wdata,
  input  logic [NUM_CLIENTS-1:0][SRAM_BE_WIDTH-1:0]      i_be,
  output logic [NUM_CLIENTS-1:0]                         o_ack,
  output logic [SRAM_DATA_WIDTH-1:0]                     o_rdata,
  output logic                                           o_busy,
  output logic [SRAM_ADDR_WIDTH-1:0]                     o_SRAM_ADDR,
  output logic [SRAM_DATA_WIDTH-1:0]                     o_SRAM_DQ,
  output logic                                           o_SRAM_DQ_OE,
  input  logic [SRAM_DATA_WIDTH-1:0]                     i_SRAM_DQ,
  output logic                                           o_SRAM_CE_N,
  output logic                                           o_SRAM_OE_N,
  output logic                                           o_SRAM_WE_N,
  output logic                                           o_SRAM_LB_N,
  output logic                                           o_SRAM_UB_N
);

  localparam int PW = $clog2(NUM_CLIENTS);
  localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;

  sram_state_t            state;
  logic [CW-1:0]          cnt;
  logic [PW-1:0]          ptr;
  logic [PW-1:0]          ptr_next;
  logic [NUM_CLIENTS-1:0] grant;
  logic [NUM_CLIENTS-1:0] owner;
  logic                   we;
  sram_req_t              reqs [NUM_CLIENTS];
  sram_req_t              sel;

  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_pack
    assign reqs[gi] = '{addr: i_addr[gi], wdata: i_wdata[gi], we: i_we[gi], be: i_be[gi]};
  end

  sram_rr_select #(.N(NUM_CLIENTS), .PW(PW)) u_select (
    .req      (i_req),
    .ptr      (ptr),
    .grant    (grant),
    .ptr_next (ptr_next)
  );

  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (grant[k]) sel = reqs[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      ptr          <= PW'(CLIENT_SPRITE);
      owner        <= '0;
      we           <= 1'b0;
      o_ack        <= '0;
      o_rdata      <= '0;
      o_busy       <= 1'b0;
      o_SRAM_ADDR  <= '0;
      o_SRAM_DQ    <= '0;
      o_SRAM_DQ_OE <= 1'b0;
      o_SRAM_CE_N  <= 1'b1;
      o_SRAM_OE_N  <= 1'b1;
      o_SRAM_WE_N  <= 1'b1;
      o_SRAM_LB_N  <= 1'b1;
      o_SRAM_UB_N  <= 1'b1;
    end else begin
      o_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (|i_req) begin
            state        <= ST_ACCESS;
            o_busy       <= 1'b1;
            cnt          <= CW'(ACCESS_CYCLES - 1);
            ptr          <= ptr_next;
            owner        <= grant;
            we           <= sel.we;
            o_SRAM_ADDR  <= sel.addr;
            o_SRAM_DQ    <= sel.wdata;
            o_SRAM_DQ_OE <= sel.we;
            o_SRAM_CE_N  <= 1'b0;
            o_SRAM_OE_N  <= sel.we;
            o_SRAM_WE_N  <= ~sel.we;
            o_SRAM_LB_N  <= ~sel.be[0];
            o_SRAM_UB_N  <= ~sel.be[1];
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            state        <= ST_IDLE;
            o_busy       <= 1'b0;
            o_ack        <= owner;
            if (!we) o_rdata <= i_SRAM_DQ;
            o_SRAM_DQ_OE <= 1'b0;
            o_SRAM_CE_N  <= 1'b1;
            o_SRAM_OE_N  <= 1'b1;
            o_SRAM_WE_N  <= 1'b1;
            o_SRAM_LB_N  <= 1'b1;
            o_SRAM_UB_N  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
            // Raise WE one cycle early so address/data hold past its rising edge.
            if (cnt == CW'(1)) o_SRAM_WE_N <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural SRAM model.
module tb_sram_arbiter;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [2:0]       req = '0;
  logic [2:0]       we = '0;
  logic [2:0][19:0] addr = '0;
  logic [2:0][15:0] wdata = '0;
  logic [2:0][1:0]  be = '0;
  logic [2:0]       ack;
  logic [15:0]      rdata;
  logic             busy;
  logic [19:0]      sram_addr;
  logic [15:0]      sram_dq;
  logic             sram_dq_oe;
  logic [15:0]      sram_rd;
  logic             ce_n, oe_n, we_n, lb_n, ub_n;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:255];

  sram_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_we         (we),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .i_be         (be),
    .o_ack        (ack),
    .o_rdata      (rdata),
    .o_busy       (busy),
    .o_SRAM_ADDR  (sram_addr),
    .o_SRAM_DQ    (sram_dq),
    .o_SRAM_DQ_OE (sram_dq_oe),
    .i_SRAM_DQ    (sram_rd),
    .o_SRAM_CE_N  (ce_n),
    .o_SRAM_OE_N  (oe_n),
    .o_SRAM_WE_N  (we_n),
    .o_SRAM_LB_N  (lb_n),
    .o_SRAM_UB_N  (ub_n)
  );

  always #5 clk = ~clk;

  // Sparse model: only the handful of addresses used here map to distinct slots.
  function automatic logic [7:0] midx(input logic [19:0] a);
    return a[7:0] + a[19:12];
  endfunction

  always_comb begin
    sram_rd = 16'h0000;
    if (!ce_n && !oe_n) sram_rd = mem[midx(sram_addr)];
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[midx(20'h4E200)] = 16'hA5C3;
    mem[midx(20'h00010)] = 16'hABCD;
    mem[midx(20'h00000)] = 16'h1111;
    mem[midx(20'h00001)] = 16'h2222;
    mem[midx(20'h00002)] = 16'h3333;
    mem[midx(20'h00003)] = 16'h4444;
    forever begin
      @(posedge we_n);
      if (ce_n === 1'b0) begin
        if (!lb_n) mem[midx(sram_addr)][7:0]  = sram_dq[7:0];
        if (!ub_n) mem[midx(sram_addr)][15:8] = sram_dq[15:8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int n, output logic [2:0] a);
    n = 0;
    a = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (ack != 3'b000) begin
        a = ack;
        break;
      end
    end
  endtask

  task automatic strobes_idle(input string tag);
    check(tag, {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
  endtask

  int         n;
  logic [2:0] a;
  int         ack0_cnt;
  logic       stray;
  logic [2:0] exp_order [4];
  logic [15:0] exp_data [4];

  initial begin
    // Reset with no clock edge involved.
    #2 rst_n = 1'b0;
    #1;
    strobes_idle("rst_strobes");
    check("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_ack", {29'd0, ack}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    strobes_idle("idle_strobes");
    $display("reset: strobes=%b%b%b%b%b ack=%b", ce_n, oe_n, we_n, lb_n, ub_n, ack);

    // Single read by the sprite client.
    addr[1] = 20'h4E200; be[1] = 2'b11; we[1] = 1'b0; req[1] = 1'b1;
    @(negedge clk);
    check("rd_c1_oe_n", {31'd0, oe_n}, 32'd0);
    check("rd_c1_ce_we", {30'd0, ce_n, we_n}, 32'd1);
    check("rd_c1_addr", {12'd0, sram_addr}, 32'h4E200);
    check("rd_c1_busy", {31'd0, busy}, 32'd1);
    check("rd_c1_ack", {29'd0, ack}, 32'd0);
    @(negedge clk);
    check("rd_c2_oe_n", {31'd0, oe_n}, 32'd0);
    check("rd_c2_ack", {29'd0, ack}, 32'd0);
    @(negedge clk);
    check("rd_ack", {29'd0, ack}, 32'b010);
    check("rd_data", {16'd0, rdata}, 32'hA5C3);
    check("rd_c3_oe_n", {31'd0, oe_n}, 32'd1);
    check("rd_c3_busy", {31'd0, busy}, 32'd0);
    $display("read c1 addr=4E200 ack=%b rdata=%h", ack, rdata);
    req[1] = 1'b0;
    @(negedge clk);
    check("rd_ack_drop", {29'd0, ack}, 32'd0);

    // Low-byte write by the loader.
    addr[2] = 20'h00010; wdata[2] = 16'h1234; be[2] = 2'b01; we[2] = 1'b1; req[2] = 1'b1;
    @(negedge clk);
    check("wr_c1_pins", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'b01001);
    check("wr_c1_oe", {31'd0, sram_dq_oe}, 32'd1);
    check("wr_c1_dq", {16'd0, sram_dq}, 32'h1234);
    @(negedge clk);
    check("wr_c2_we_n", {31'd0, we_n}, 32'd1);
    check("wr_c2_oe", {31'd0, sram_dq_oe}, 32'd1);
    check("wr_c2_ce_n", {31'd0, ce_n}, 32'd0);
    @(negedge clk);
    check("wr_ack", {29'd0, ack}, 32'b100);
    check("wr_c3_oe", {31'd0, sram_dq_oe}, 32'd0);
    req[2] = 1'b0; we[2] = 1'b0;
    @(negedge clk);
    check("wr_mem", {16'd0, mem[midx(20'h00010)]}, 32'hAB34);
    $display("write c2 addr=00010 be=01 mem=%h", mem[midx(20'h00010)]);

    // Priority: everyone requests, VGA must take every slot.
    addr[0] = 20'h00000; be[0] = 2'b11;
    addr[1] = 20'h4E200; be[1] = 2'b11;
    addr[2] = 20'h00010; be[2] = 2'b11;
    req = 3'b111;
    ack0_cnt = 0;
    stray = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack[2:1] != 2'b00) stray = 1'b1;
      if (ack[0]) begin
        ack0_cnt++;
        if (ack0_cnt == 4) req[0] = 1'b0;
      end
    end
    check("prio_ack0_count", ack0_cnt, 32'd4);
    check("prio_no_stray", {31'd0, stray}, 32'd0);
    $display("priority: vga acks=%0d stray=%b", ack0_cnt, stray);

    exp_order[0] = 3'b010; exp_order[1] = 3'b100;
    exp_order[2] = 3'b010; exp_order[3] = 3'b100;
    for (int i = 0; i < 4; i++) begin
      wait_ack(n, a);
      check($sformatf("rr_grant%0d", i), {29'd0, a}, {29'd0, exp_order[i]});
      check($sformatf("rr_space%0d", i), n, 32'd3);
      $display("round-robin %0d: ack=%b gap=%0d", i, a, n);
      if (i == 3) req = 3'b000;
    end
    @(negedge clk);

    // Back-to-back VGA stream.
    exp_data[0] = 16'h1111; exp_data[1] = 16'h2222;
    exp_data[2] = 16'h3333; exp_data[3] = 16'h4444;
    addr[0] = 20'h00000; req[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(n, a);
      check($sformatf("b2b_ack%0d", i), {29'd0, a}, 32'b001);
      check($sformatf("b2b_space%0d", i), n, 32'd3);
      check($sformatf("b2b_data%0d", i), {16'd0, rdata}, {16'd0, exp_data[i]});
      $display("stream %0d: ack=%b gap=%0d rdata=%h", i, a, n, rdata);
      if (i < 3) addr[0] = 20'(i + 1);
      else req[0] = 1'b0;
    end
    @(negedge clk);

    // Reset in the middle of a write.
    addr[2] = 20'h00020; wdata[2] = 16'hBEEF; be[2] = 2'b11; we[2] = 1'b1; req[2] = 1'b1;
    @(negedge clk);
    check("mw_we_low", {31'd0, we_n}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    strobes_idle("mw_strobes");
    check("mw_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("mw_addr", {12'd0, sram_addr}, 32'd0);
    check("mw_busy_ack", {28'd0, busy, ack}, 32'd0);
    req = 3'b000; we = 3'b000;
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack != 3'b000) stray = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (ack != 3'b000) stray = 1'b1;
    end
    check("mw_no_ack", {31'd0, stray}, 32'd0);
    $display("reset mid-write: we_n=%b stray_ack=%b", we_n, stray);

    addr[1] = 20'h4E200; be[1] = 2'b11; req[1] = 1'b1;
    wait_ack(n, a);
    check("post_rst_ack", {29'd0, a}, 32'b010);
    check("post_rst_space", n, 32'd3);
    check("post_rst_data", {16'd0, rdata}, 32'hA5C3);
    $display("after reset: ack=%b rdata=%h", a, rdata);
    req = 3'b000;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
